ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 143 ++++++++++++++
 tb/tb_ram_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port round-robin arbiter in front of a single-port RAM.
// Each request is latched into a one-cycle ACCESS slot, which drives the RAM.
// At the edge that ends the slot, the served port gets a one-cycle ack pulse.
// Misaligned or out-of-range addresses complete with err set and never write.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   reqN/weN/adrN/dinN     port N request, write enable, byte address, write data
//   ackN/errN/rdataN       port N completion pulse, error flag, read data
//   mem_we/mem_adr/mem_din shared RAM drive (all 0 while idle)
//   mem_dout               combinational RAM read data
module ram_arbiter #(
  parameter int WIDTH = 32,
  parameter int ABITS = 32,
  parameter int DEPTH = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             we0,
  input  logic [ABITS-1:0] adr0,
  input  logic [WIDTH-1:0] din0,
  output logic             ack0,
  output logic             err0,
  output logic [WIDTH-1:0] rdata0,
  input  logic             req1,
  input  logic             we1,
  input  logic [ABITS-1:0] adr1,
  input  logic [WIDTH-1:0] din1,
  output logic             ack1,
  output logic             err1,
  output logic [WIDTH-1:0] rdata1,
  output logic             mem_we,
  output logic [ABITS-1:0] mem_adr,
  output logic [WIDTH-1:0] mem_din,
  input  logic [WIDTH-1:0] mem_dout
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t           state_q, state_d;
  logic             sel_q, sel_d;    // port id owning the current ACCESS slot
  logic             prio_q, prio_d;  // port favoured on a tie
  logic             we_q, we_d;
  logic [ABITS-1:0] adr_q, adr_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic             err_q, err_d;
  logic             ack0_q, ack0_d, ack1_q, ack1_d;
  logic             err0_q, err0_d, err1_q, err1_d;
  logic [WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic done0, done1, elig0, elig1, win;

  function automatic logic addr_err(input logic [ABITS-1:0] a);
    logic [ABITS-1:0] dep;
    dep = ABITS'(DEPTH);
    return (a[1:0] != 2'b00) || ({2'b00, a[ABITS-1:2]} >= dep);
  endfunction

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    prio_d   = prio_q;
    we_d     = 1'b0;
    adr_d    = '0;
    din_d    = '0;
    err_d    = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    done0 = (state_q == ACCESS) && !sel_q;
    done1 = (state_q == ACCESS) &&  sel_q;

    // The port completing at this edge is still holding its request;
    // it must not be re-granted until it has seen its ack.
    elig0 = req0 && !done0;
    elig1 = req1 && !done1;
    win   = (elig0 && elig1) ? prio_q : elig1;

    if (elig0 || elig1) begin
      state_d = ACCESS;
      sel_d   = win;
      prio_d  = ~win;
      we_d    = win ? we1  : we0;
      adr_d   = win ? adr1 : adr0;
      din_d   = win ? din1 : din0;
      err_d   = addr_err(win ? adr1 : adr0);
    end else begin
      state_d = IDLE;
    end

    ack0_d = done0;
    ack1_d = done1;
    err0_d = done0 && err_q;
    err1_d = done1 && err_q;
    if (done0) rdata0_d = (we_q || err_q) ? '0 : mem_dout;
    if (done1) rdata1_d = (we_q || err_q) ? '0 : mem_dout;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      prio_q   <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      din_q    <= '0;
      err_q    <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      prio_q   <= prio_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      din_q    <= din_d;
      err_q    <= err_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign mem_we  = (state_q == ACCESS) && we_q && !err_q;
  assign mem_adr = (state_q == ACCESS) ? adr_q : '0;
  assign mem_din = (state_q == ACCESS) ? din_q : '0;

  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign err0   = err0_q;
  assign err1   = err1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

  localparam int WIDTH = 32;
  localparam int ABITS = 32;
  localparam int DEPTH = 128;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0, we0, req1, we1;
  logic [ABITS-1:0] adr0, adr1;
  logic [WIDTH-1:0] din0, din1;
  logic             ack0, err0, ack1, err1;
  logic [WIDTH-1:0] rdata0, rdata1;
  logic             mem_we;
  logic [ABITS-1:0] mem_adr;
  logic [WIDTH-1:0] mem_din, mem_dout;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ABITS-3:0] widx;
  int               n_cmp = 0;
  int               n_bad = 0;
  int               n_writes = 0;
  int               n_ack0 = 0;

  ram_arbiter #(.WIDTH(WIDTH), .ABITS(ABITS), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .adr0(adr0), .din0(din0),
    .ack0(ack0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .adr1(adr1), .din1(din1),
    .ack1(ack1), .err1(err1), .rdata1(rdata1),
    .mem_we(mem_we), .mem_adr(mem_adr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: combinational read, write on rising edge.
  assign widx     = mem_adr[ABITS-1:2];
  assign mem_dout = (widx < DEPTH) ? mem[widx] : '0;

  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      n_writes <= n_writes + 1;
      if (widx < DEPTH) mem[widx] <= mem_din;
    end
    if (ack0 === 1'b1) n_ack0 <= n_ack0 + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_zero"},
             {31'd0, mem_we, mem_adr}, 64'd0);
    check_eq({tag, "_zero2"},
             {mem_din, 28'd0, ack0, ack1, err0, err1}, 64'd0);
    check_eq({tag, "_zero3"}, {rdata0, rdata1}, 64'd0);
  endtask

  // Issue one access on port p and wait (bounded) for its ack.
  task automatic access(input int p, input logic w, input logic [ABITS-1:0] a,
                        input logic [WIDTH-1:0] d, output logic [WIDTH-1:0] rd,
                        output logic er, output int edges);
    logic got;
    got = 1'b0; rd = '0; er = 1'b0; edges = 0;
    if (p == 0) begin req0 = 1'b1; we0 = w; adr0 = a; din0 = d; end
    else        begin req1 = 1'b1; we1 = w; adr1 = a; din1 = d; end
    while (!got && edges < 8) begin
      tick();
      edges++;
      if ((p == 0) ? ack0 : ack1) begin
        got = 1'b1;
        rd  = (p == 0) ? rdata0 : rdata1;
        er  = (p == 0) ? err0 : err1;
      end
    end
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  logic [WIDTH-1:0] rd;
  logic             er;
  int               edges;
  int               wsnap;

  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) mem[i] = '0;
    reset = 1'b1;
    req0 = 1'b0; we0 = 1'b0; adr0 = '0; din0 = '0;
    req1 = 1'b0; we1 = 1'b0; adr1 = '0; din1 = '0;
    #12;
    check_all_zero("reset");
    tick();
    reset = 1'b0;
    tick();

    // Write then read on port 0.
    access(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, rd, er, edges);
    check_eq("wr_edges", edges, 2);
    check_eq("wr_rdata", rd, 0);
    check_eq("wr_err", er, 0);
    check_eq("wr_mem", mem[4], 32'hDEAD_BEEF);
    access(0, 1'b0, 32'h0000_0010, 32'h0, rd, er, edges);
    check_eq("rd_edges", edges, 2);
    check_eq("rd_rdata", rd, 32'hDEAD_BEEF);
    check_eq("rd_err", er, 0);
    tick();
    check_eq("rd_hold_ack", ack0, 0);
    check_eq("rd_hold_rdata", rdata0, 32'hDEAD_BEEF);

    // Simultaneous reads after reset: port 0 first, then port 1.
    reset = 1'b1; tick(); reset = 1'b0;
    mem[5] = 32'h0000_A5A5; mem[6] = 32'h0000_5A5A;
    req0 = 1'b1; we0 = 1'b0; adr0 = 32'h14;
    req1 = 1'b1; we1 = 1'b0; adr1 = 32'h18;
    tick();
    check_eq("sim_e1_acks", {ack0, ack1}, 2'b00);
    tick();
    check_eq("sim_e2_acks", {ack0, ack1}, 2'b10);
    check_eq("sim_e2_rdata0", rdata0, 32'h0000_A5A5);
    req0 = 1'b0;
    tick();
    check_eq("sim_e3_acks", {ack0, ack1}, 2'b01);
    check_eq("sim_e3_rdata1", rdata1, 32'h0000_5A5A);
    req1 = 1'b0;
    tick();
    check_eq("sim_e4_acks", {ack0, ack1}, 2'b00);

    // Round robin: port 0 writes word 8, port 1 reads word 5, both held.
    req0 = 1'b1; we0 = 1'b1; adr0 = 32'h20; din0 = 32'h1111_0000;
    req1 = 1'b1; we1 = 1'b0; adr1 = 32'h14;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check_eq($sformatf("rr_k%0d_acks", k), {ack0, ack1},
               (k >= 2 && k <= 9) ? ((k % 2 == 0) ? 2'b10 : 2'b01) : 2'b00);
      check_eq($sformatf("rr_k%0d_we", k), mem_we, (k <= 8 && k % 2 == 1) ? 1'b1 : 1'b0);
      if (k >= 3 && k <= 9 && k % 2 == 1)
        check_eq($sformatf("rr_k%0d_rdata1", k), rdata1, 32'h0000_A5A5);
      if (k == 8) req0 = 1'b0;
      if (k == 9) req1 = 1'b0;
    end
    check_eq("rr_mem", mem[8], 32'h1111_0000);

    // Address errors on port 1, plus the last valid word.
    mem[0] = 32'hCAFE_0000; mem[127] = 32'h7F7F_7F7F;
    wsnap = n_writes;
    access(1, 1'b1, 32'h0000_0003, 32'hFFFF_FFFF, rd, er, edges);
    check_eq("err_mis_edges", edges, 2);
    check_eq("err_mis_err", er, 1);
    check_eq("err_mis_rdata", rd, 0);
    access(1, 1'b1, 32'h0000_0200, 32'hFFFF_FFFF, rd, er, edges);
    check_eq("err_oor_edges", edges, 2);
    check_eq("err_oor_err", er, 1);
    check_eq("err_oor_rdata", rd, 0);
    check_eq("err_no_writes", n_writes - wsnap, 0);
    check_eq("err_mem0", mem[0], 32'hCAFE_0000);
    access(1, 1'b0, 32'h0000_01FC, 32'h0, rd, er, edges);
    check_eq("last_word_err", er, 0);
    check_eq("last_word_rdata", rd, 32'h7F7F_7F7F);

    // Reset in the middle of an ACCESS cycle.
    mem[1] = 32'hAAAA_5555;
    wsnap = n_writes;
    req0 = 1'b1; we0 = 1'b1; adr0 = 32'h4; din0 = 32'h1234_5678;
    tick();
    check_eq("rst_mid_we", mem_we, 1);
    #1 reset = 1'b1;
    #1 check_all_zero("rst_mid");
    req0 = 1'b0;
    #4 reset = 1'b0;
    wsnap = n_ack0;
    tick(); tick(); tick();
    check_eq("rst_mid_no_ack", n_ack0 - wsnap, 0);
    check_eq("rst_mid_mem1", mem[1], 32'hAAAA_5555);
    access(0, 1'b0, 32'h4, 32'h0, rd, er, edges);
    check_eq("post_rst_edges", edges, 2);
    check_eq("post_rst_rdata", rd, 32'hAAAA_5555);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
